// File: rtl/pll_reset_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN
    } pll_state_e;

    localparam int DEF_NUM_DOMAINS         = 6;
    localparam int DEF_PLL_RESET_CYCLES    = 32;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_RELEASE_GAP_CYCLES  = 16;

    // Counter width for a cycle count: $clog2 with a floor of one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Resets a PLL, waits for stable lock, then releases downstream domain resets
// one at a time; any lock loss reasserts every domain reset.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int RELEASE_GAP_CYCLES  = DEF_RELEASE_GAP_CYCLES
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   pll_lock_i,
    output logic                   pll_reset_o,
    output logic [NUM_DOMAINS-1:0] domain_reset_o,
    output logic                   ready_o,
    output logic [7:0]             lock_loss_count_o,
    output logic [7:0]             retry_count_o,
    output pll_state_e             state_o
);

    localparam int PW = cnt_width(PLL_RESET_CYCLES);
    localparam int TW = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int SW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int GW = cnt_width(RELEASE_GAP_CYCLES);

    localparam logic [PW-1:0] PLL_LAST    = PW'(PLL_RESET_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(RELEASE_GAP_CYCLES - 1);

    pll_state_e             state_q, state_d;
    logic [PW-1:0]          pll_timer_q, pll_timer_d;
    logic [TW-1:0]          lock_timer_q, lock_timer_d;
    logic [SW-1:0]          stable_q, stable_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   pll_reset_q, pll_reset_d;
    logic [NUM_DOMAINS-1:0] domain_q, domain_d;
    logic                   ready_q, ready_d;
    logic [7:0]             loss_q, loss_d;
    logic [7:0]             retry_q, retry_d;
    logic                   lock_s;

    sync_2ff u_lock_sync (
        .clk_i (clock_i),
        .rst_i (reset_i),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= PLL_RST;
            pll_timer_q  <= '0;
            lock_timer_q <= '0;
            stable_q     <= '0;
            gap_q        <= '0;
            pll_reset_q  <= 1'b1;
            domain_q     <= '1;
            ready_q      <= 1'b0;
            loss_q       <= '0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            pll_timer_q  <= pll_timer_d;
            lock_timer_q <= lock_timer_d;
            stable_q     <= stable_d;
            gap_q        <= gap_d;
            pll_reset_q  <= pll_reset_d;
            domain_q     <= domain_d;
            ready_q      <= ready_d;
            loss_q       <= loss_d;
            retry_q      <= retry_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pll_timer_d  = pll_timer_q;
        lock_timer_d = lock_timer_q;
        stable_d     = stable_q;
        gap_d        = gap_q;
        pll_reset_d  = pll_reset_q;
        domain_d     = domain_q;
        ready_d      = ready_q;
        loss_d       = loss_q;
        retry_d      = retry_q;

        case (state_q)
            PLL_RST: begin
                if (pll_timer_q == PLL_LAST) begin
                    state_d      = WAIT_LOCK;
                    pll_reset_d  = 1'b0;
                    pll_timer_d  = '0;
                    lock_timer_d = '0;
                end else begin
                    pll_timer_d = pll_timer_q + PW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = STABILIZE;
                    stable_d = '0;
                end else if (lock_timer_q == TIMEOUT_LAST) begin
                    state_d     = PLL_RST;
                    pll_reset_d = 1'b1;
                    pll_timer_d = '0;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end else begin
                    lock_timer_d = lock_timer_q + TW'(1);
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d      = WAIT_LOCK;
                    lock_timer_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    // Bit 0 drops on the same edge that enters RELEASE.
                    state_d  = RELEASE;
                    gap_d    = '0;
                    domain_d = {NUM_DOMAINS{1'b1}} << 1;
                end else begin
                    stable_d = stable_q + SW'(1);
                end
            end
            RELEASE, RUN: begin
                // Loss has priority over the final release step and the RUN entry.
                if (!lock_s) begin
                    state_d      = WAIT_LOCK;
                    lock_timer_d = '0;
                    domain_d     = '1;
                    ready_d      = 1'b0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (state_q == RELEASE) begin
                    if (domain_q == '0) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else if (gap_q == GAP_LAST) begin
                        domain_d = domain_q << 1;
                        gap_d    = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d     = PLL_RST;
                pll_reset_d = 1'b1;
                pll_timer_d = '0;
                domain_d    = '1;
                ready_d     = 1'b0;
            end
        endcase
    end

    assign pll_reset_o       = pll_reset_q;
    assign domain_reset_o    = domain_q;
    assign ready_o           = ready_q;
    assign lock_loss_count_o = loss_q;
    assign retry_count_o     = retry_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized lock patterns against a phase/elapsed-time model of
// the sequencer, compared every cycle through an expected-value queue.
module tb_pll_reset_sequencer;
    import pll_reset_pkg::*;

    localparam int N = 3;
    localparam int P = 4;
    localparam int T = 64;
    localparam int S = 8;
    localparam int G = 4;
    localparam int W = 21;

    localparam int M_PLLRST = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STAB   = 2;
    localparam int M_REL    = 3;
    localparam int M_RUN    = 4;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         pll_lock_i;
    logic         pll_reset_o;
    logic [N-1:0] domain_reset_o;
    logic         ready_o;
    logic [7:0]   lock_loss_count_o;
    logic [7:0]   retry_count_o;
    pll_state_e   state_o;

    pll_reset_sequencer #(
        .NUM_DOMAINS         (N),
        .PLL_RESET_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .RELEASE_GAP_CYCLES  (G)
    ) dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .pll_lock_i        (pll_lock_i),
        .pll_reset_o       (pll_reset_o),
        .domain_reset_o    (domain_reset_o),
        .ready_o           (ready_o),
        .lock_loss_count_o (lock_loss_count_o),
        .retry_count_o     (retry_count_o),
        .state_o           (state_o)
    );

    // Clock: inputs change and outputs are sampled on the falling edge.
    always #5 clock_i = ~clock_i;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Model: current phase, edges elapsed in that phase, counters, lock history.
    int m_mode, m_t, m_loss, m_retry;
    bit lk_q[$];

    function automatic logic [W-1:0] model_out();
        logic         pll;
        logic         rdy;
        logic [N-1:0] dom;
        int           rel;
        pll = (m_mode == M_PLLRST);
        rdy = (m_mode == M_RUN);
        dom = '1;
        if (m_mode == M_RUN) begin
            dom = '0;
        end else if (m_mode == M_REL) begin
            rel = m_t / G + 1;
            if (rel > N) rel = N;
            for (int i = 0; i < rel; i++) dom[i] = 1'b0;
        end
        return {pll, rdy, dom, 8'(m_loss), 8'(m_retry)};
    endfunction

    task automatic model_reset();
        m_mode  = M_PLLRST;
        m_t     = 0;
        m_loss  = 0;
        m_retry = 0;
        lk_q    = '{1'b0, 1'b0};
        exp_q.push_back(model_out());
    endtask

    task automatic goto_mode(input int mode);
        m_mode = mode;
        m_t    = 0;
    endtask

    // Lock seen at an edge is the pll_lock_i level sampled two edges earlier.
    task automatic model_edge(input bit lock);
        bit l;
        l = lk_q[lk_q.size() - 2];
        lk_q.push_back(lock);
        if (lk_q.size() > 4) void'(lk_q.pop_front());
        case (m_mode)
            M_PLLRST: begin
                m_t++;
                if (m_t == P) goto_mode(M_WAIT);
            end
            M_WAIT: begin
                if (l) begin
                    goto_mode(M_STAB);
                end else begin
                    m_t++;
                    if (m_t == T) begin
                        goto_mode(M_PLLRST);
                        if (m_retry < 255) m_retry++;
                    end
                end
            end
            M_STAB: begin
                if (!l) begin
                    goto_mode(M_WAIT);
                end else begin
                    m_t++;
                    if (m_t == S) goto_mode(M_REL);
                end
            end
            default: begin
                if (!l) begin
                    goto_mode(M_WAIT);
                    if (m_loss < 255) m_loss++;
                end else if (m_mode == M_REL) begin
                    m_t++;
                    if (m_t == (N - 1) * G + 1) goto_mode(M_RUN);
                end
            end
        endcase
        exp_q.push_back(model_out());
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic compare_outputs();
        logic [W-1:0] e;
        check("sb_not_empty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pll_reset_o", 32'(pll_reset_o), 32'(e[20]));
            check("ready_o", 32'(ready_o), 32'(e[19]));
            check("domain_reset_o", 32'(domain_reset_o), 32'(e[18:16]));
            check("lock_loss_count_o", 32'(lock_loss_count_o), 32'(e[15:8]));
            check("retry_count_o", 32'(retry_count_o), 32'(e[7:0]));
        end
    endtask

    // Driver: one clock cycle with the given lock level, checked at the falling edge.
    task automatic step(input bit lock);
        pll_lock_i = lock;
        @(posedge clock_i);
        model_edge(lock);
        @(negedge clock_i);
        compare_outputs();
    endtask

    task automatic run_until(input string tag, input bit lock, input int mode,
                             input int t, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step(lock);
            hit = (m_mode == mode) && (m_t == t);
        end
        check({"reach_", tag}, 32'(hit), 32'd1);
    endtask

    initial begin
        reset_i    = 1'b1;
        pll_lock_i = 1'b1;
        model_reset();
        repeat (3) @(negedge clock_i);
        compare_outputs();
        reset_i = 1'b0;

        // Clean bring-up with lock held high.
        run_until("first_run", 1'b1, M_RUN, 0, 100);
        repeat (5) step(1'b1);
        check("run_ready", 32'(ready_o), 32'd1);
        check("run_no_loss", 32'(lock_loss_count_o), 32'd0);

        // One-cycle lock drop in RUN, then resequence without a PLL reset.
        step(1'b0);
        repeat (3) step(1'b1);
        check("loss_dom", 32'(domain_reset_o), 32'h7);
        check("loss_count", 32'(lock_loss_count_o), 32'd1);
        run_until("rerun", 1'b1, M_RUN, 0, 100);

        // Lock glitch during stabilization restarts the stable count.
        step(1'b0);
        run_until("stab3", 1'b1, M_STAB, 3, 100);
        step(1'b0);
        run_until("run_after_glitch", 1'b1, M_RUN, 0, 100);

        // Lock loss landing on the edge that would release bit 2.
        step(1'b0);
        run_until("rel5", 1'b1, M_REL, 5, 100);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("coincide_dom", 32'(domain_reset_o), 32'h7);
        check("coincide_ready", 32'(ready_o), 32'd0);
        run_until("run_after_coincide", 1'b1, M_RUN, 0, 100);

        // Asynchronous reset in the middle of the release ramp.
        step(1'b0);
        run_until("rel5_b", 1'b1, M_REL, 5, 100);
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        repeat (2) @(negedge clock_i);
        exp_q.push_back(model_out());
        compare_outputs();
        pll_lock_i = 1'b0;
        reset_i    = 1'b0;

        // Lock never arrives: periodic PLL resets and saturating retry count.
        repeat (257 * (T + P) + 10) step(1'b0);
        check("retry_saturated", 32'(retry_count_o), 32'd255);
        check("retry_dom", 32'(domain_reset_o), 32'h7);

        // Randomized lock bursts, mostly long highs with short dropouts.
        for (int seg = 0; seg < 80; seg++) begin
            bit lv;
            int len;
            lv  = ($urandom_range(0, 3) != 0);
            len = lv ? $urandom_range(1, 40) : $urandom_range(1, 5);
            repeat (len) step(lv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 6, giving the number of downstream reset outputs (1..8).
REQ-002 SHALL have parameter PLL_RESET_CYCLES, default 32, giving the pll_reset_o pulse length in clock_i cycles.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, giving the maximum wait for lock before the PLL is reset again.
REQ-004 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the consecutive synchronized-lock cycles required before any reset is released.
REQ-005 SHALL have parameter RELEASE_GAP_CYCLES, default 16, giving the spacing between successive domain reset releases.
REQ-006 clock_i  input  1  free-running reference clock, independent of the PLL outputs.
REQ-007 reset_i  input  1  asynchronous, active-high reset.
REQ-008 pll_lock_i  input  1  PLL lock indication, asynchronous to clock_i.
REQ-009 pll_reset_o  output  1  active-high PLL reset request.
REQ-010 domain_reset_o  output  NUM_DOMAINS  active-high reset per PLL clock domain; bit 0 is released first.
REQ-011 ready_o  output  1  high when all domain resets are released.
REQ-012 lock_loss_count_o  output  8  saturating count of lock losses after a release has begun.
REQ-013 retry_count_o  output  8  saturating count of lock timeouts.

Function
REQ-014 pll_lock_i SHALL pass through a 2-flop synchronizer; "lock" below means the synchronizer output.
REQ-015 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STABILIZE, RELEASE and RUN.
REQ-016 In PLL_RST, pll_reset_o SHALL be high for exactly PLL_RESET_CYCLES cycles, after which the FSM SHALL enter WAIT_LOCK with pll_reset_o low.
REQ-017 In WAIT_LOCK, lock high SHALL cause entry to STABILIZE on the next cycle with the stable counter cleared.
REQ-018 In WAIT_LOCK, a lock timer reaching LOCK_TIMEOUT_CYCLES-1 with lock low SHALL cause entry to PLL_RST and increment retry_count_o, saturating at 255.
REQ-019 In STABILIZE, lock low SHALL return the FSM to WAIT_LOCK with the timer cleared; no counter SHALL change.
REQ-020 STABILIZE SHALL enter RELEASE after LOCK_STABLE_CYCLES consecutive lock-high cycles, with the release index set to 0.
REQ-021 On the first RELEASE cycle, domain_reset_o[0] SHALL deassert; each further bit SHALL deassert RELEASE_GAP_CYCLES after the previous bit, in ascending order.
REQ-022 Once the last bit is deasserted, the FSM SHALL enter RUN on the next cycle and ready_o SHALL go high.
REQ-023 In RELEASE or RUN, lock low SHALL, on the next cycle, assert all domain_reset_o bits, drive ready_o low, increment lock_loss_count_o (saturating at 255) and enter WAIT_LOCK.
REQ-024 If lock loss and the final release coincide, the loss SHALL win: resets are reasserted and RUN is not entered.
REQ-025 Released bits SHALL stay low until a loss or reset_i; no bit SHALL glitch; every output SHALL come directly from a flop.
REQ-026 A pll_reset_o pulse SHALL occur only in PLL_RST; a lock loss SHALL NOT reset the PLL unless the subsequent wait times out.
REQ-027 Counter widths SHALL be $clog2 of their parameter, with a minimum of 1.

Reset
REQ-028 When reset_i is asserted, the FSM SHALL go to PLL_RST immediately, with pll_reset_o=1, all domain_reset_o bits=1, ready_o=0, both counts=0, all timers=0 and the synchronizer=0.
REQ-029 Reset asserted mid-RELEASE or mid-RUN SHALL reassert all domain resets asynchronously.
REQ-030 After reset_i deasserts, a full PLL_RST pulse SHALL occur.

Structure
REQ-031 The FSM state enum and the default parameter constants SHALL live in the shared package pll_reset_pkg.
REQ-032 The synchronizer SHALL be a sub-module named sync_2ff.
REQ-033 Downstream domains SHALL resynchronize deassertion of domain_reset_o in their own clock; this block does not do so.

Verification (NUM_DOMAINS=3, PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=8, RELEASE_GAP_CYCLES=4)
REQ-034 Release reset_i with lock held high -> pll_reset_o high for 4 cycles; domain_reset_o goes 3'b111 -> 3'b110 -> 3'b100 -> 3'b000 at 4-cycle spacing; ready_o then high; counts 0.
REQ-035 Lock held low -> pll_reset_o pulses again every 64+4 cycles; retry_count_o increments per timeout and saturates at 255; domain resets stay 3'b111.
REQ-036 Lock drops for 1 cycle after 5 stable cycles -> no release; the stable count restarts; release occurs only after a fresh 8 consecutive lock-high cycles.
REQ-037 Lock drops in RUN -> domain_reset_o=3'b111 and ready_o=0 within 3 cycles of the pll_lock_i edge; lock_loss_count_o=1; resequencing occurs with no pll_reset_o pulse.
REQ-038 Lock drop on the same cycle as bit 2 releasing -> all bits reasserted, RUN never entered, lock_loss_count_o=1.
REQ-039 reset_i asserted mid-RELEASE -> outputs reach their REQ-028 values with no clock edge needed.
